// File: rtl/l15_resp_serializer.sv
`default_nettype none
// ============================================================================
// Module      : l15_resp_serializer
// Description : Captures one full L1.5 response line and its header, then
//               streams the line out as BEAT_BITS-wide beats under a
//               valid/ready handshake. A queued response is captured on the
//               last-beat handshake, so back-to-back responses leave no bubble.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   sole clock, rising edge
//   rst_n         in   synchronous active-low reset
//   l15_val       in   response valid, held until l15_ack
//   l15_hdr       in   opaque response header (HDR_W)
//   l15_data      in   full response line, beat i at [i*BEAT_BITS +: BEAT_BITS]
//   l15_nbeats    in   number of valid beats (0 = header-only)
//   l15_ack       out  one-cycle registered capture acknowledge
//   out_val       out  beat valid
//   out_rdy       in   consumer ready
//   out_hdr       out  captured header, constant across a response
//   out_data      out  current beat
//   out_beat_idx  out  index of the current beat
//   out_last      out  final beat of the response
// ============================================================================
module l15_resp_serializer #(
    parameter  int L15_L1D_LINE_SIZE = 64,
    parameter  int BEAT_BITS         = 64,
    parameter  int HDR_W             = 16,
    localparam int LINE_W            = L15_L1D_LINE_SIZE * 8,
    localparam int MAX_BEATS         = LINE_W / BEAT_BITS,
    localparam int NB_W              = $clog2(MAX_BEATS) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 l15_val,
    input  logic [HDR_W-1:0]     l15_hdr,
    input  logic [LINE_W-1:0]    l15_data,
    input  logic [NB_W-1:0]      l15_nbeats,
    output logic                 l15_ack,
    output logic                 out_val,
    input  logic                 out_rdy,
    output logic [HDR_W-1:0]     out_hdr,
    output logic [BEAT_BITS-1:0] out_data,
    output logic [NB_W-2:0]      out_beat_idx,
    output logic                 out_last
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if ((LINE_W % BEAT_BITS) != 0) begin : g_bad_line_w
            $error("l15_resp_serializer: line width must be a multiple of BEAT_BITS");
        end
        if (MAX_BEATS < 2) begin : g_bad_max_beats
            $error("l15_resp_serializer: at least two beats per line are required");
        end
    endgenerate

    localparam logic [NB_W-1:0] c_MAX_CNT = NB_W'(MAX_BEATS);
    localparam logic [NB_W-1:0] c_ONE     = NB_W'(1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_SEND = 1'b1;

    logic [0:0]           r_state;
    logic [HDR_W-1:0]     r_hdr;
    logic [LINE_W-1:0]    r_line;
    logic [NB_W-1:0]      r_cnt;
    logic [NB_W-2:0]      r_idx;
    logic                 r_ack;
    logic                 r_out_val;
    logic                 r_out_last;
    logic [BEAT_BITS-1:0] r_out_data;

    logic                 w_hs;
    logic                 w_last_hs;
    logic                 w_capture;
    logic                 w_zero_beats;
    logic [NB_W-1:0]      w_cnt_eff;
    logic [NB_W-2:0]      w_idx_nxt;
    logic [BEAT_BITS-1:0] w_next_beat;
    logic                 w_next_last;

    assign w_hs      = r_out_val & out_rdy;
    assign w_last_hs = w_hs & r_out_last;
    // The registered ack blocks a second capture of the same response while
    // the L1.5 is still holding val during the ack cycle.
    assign w_capture = l15_val & ~r_ack & ((r_state == c_IDLE) | w_last_hs);

    // A header-only response still occupies one beat; oversize counts clamp.
    assign w_zero_beats = (l15_nbeats == '0);

    always_comb begin
        w_cnt_eff = l15_nbeats;
        if (w_zero_beats) begin
            w_cnt_eff = c_ONE;
        end else if (l15_nbeats > c_MAX_CNT) begin
            w_cnt_eff = c_MAX_CNT;
        end
    end

    // Beat data and last flag are precomputed for the following beat so that
    // every out_* signal comes straight from a register.
    assign w_idx_nxt   = r_idx + 1'b1;
    assign w_next_beat = r_line[w_idx_nxt*BEAT_BITS +: BEAT_BITS];
    assign w_next_last = ({1'b0, w_idx_nxt} == (r_cnt - c_ONE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_hdr      <= '0;
            r_line     <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_ack      <= 1'b0;
            r_out_val  <= 1'b0;
            r_out_last <= 1'b0;
            r_out_data <= '0;
        end else begin
            r_ack <= w_capture;
            if (w_capture) begin
                r_state    <= c_SEND;
                r_hdr      <= l15_hdr;
                r_line     <= l15_data;
                r_cnt      <= w_cnt_eff;
                r_idx      <= '0;
                r_out_val  <= 1'b1;
                r_out_last <= (w_cnt_eff == c_ONE);
                r_out_data <= w_zero_beats ? '0 : l15_data[BEAT_BITS-1:0];
            end else if (w_last_hs) begin
                r_state    <= c_IDLE;
                r_out_val  <= 1'b0;
                r_out_last <= 1'b0;
            end else if (w_hs) begin
                r_idx      <= w_idx_nxt;
                r_out_data <= w_next_beat;
                r_out_last <= w_next_last;
            end
        end
    end

    assign l15_ack      = r_ack;
    assign out_val      = r_out_val;
    assign out_hdr      = r_hdr;
    assign out_data     = r_out_data;
    assign out_beat_idx = r_idx;
    assign out_last     = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_l15_resp_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_l15_resp_serializer
// Description : Self-checking bench for l15_resp_serializer. Responses are
//               driven by per-scenario tasks; the expected beat stream is
//               queued at drive time and popped by a monitor on handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l15_resp_serializer;

    typedef struct packed {
        logic [15:0] hdr;
        logic [63:0] data;
        logic [2:0]  idx;
        logic        last;
    } beat_t;

    logic         clk;
    logic         rst_n;
    logic         l15_val;
    logic [15:0]  l15_hdr;
    logic [511:0] l15_data;
    logic [3:0]   l15_nbeats;
    logic         l15_ack;
    logic         out_val;
    logic         out_rdy;
    logic [15:0]  out_hdr;
    logic [63:0]  out_data;
    logic [2:0]   out_beat_idx;
    logic         out_last;

    int    checks;
    int    errors;
    int    cyc;
    int    ack_count;
    beat_t sb[$];
    int    hs_cycles[$];
    logic  stalled_prev;
    beat_t prev_snap;

    l15_resp_serializer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .l15_val      (l15_val),
        .l15_hdr      (l15_hdr),
        .l15_data     (l15_data),
        .l15_nbeats   (l15_nbeats),
        .l15_ack      (l15_ack),
        .out_val      (out_val),
        .out_rdy      (out_rdy),
        .out_hdr      (out_hdr),
        .out_data     (out_data),
        .out_beat_idx (out_beat_idx),
        .out_last     (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: scoreboard pop on every handshake, plus hold check while stalled.
    initial stalled_prev = 1'b0;
    always @(negedge clk) begin
        beat_t got;
        beat_t exp;
        got = '{hdr: out_hdr, data: out_data, idx: out_beat_idx, last: out_last};
        if (rst_n && out_val) begin
            if (stalled_prev) begin
                checks++;
                if (got !== prev_snap) begin
                    errors++;
                    $display("FAIL stall_hold: got %h required %h", got, prev_snap);
                end
            end
            if (out_rdy) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got %h required none", got);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL beat: got %h required %h", got, exp);
                    end
                end
                hs_cycles.push_back(cyc);
            end
            stalled_prev = !out_rdy;
            prev_snap    = got;
        end else begin
            stalled_prev = 1'b0;
        end
        if (l15_ack) ack_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one response, queues its expected beats and waits for the ack,
    // which must arrive exactly one cycle after val is presented.
    task automatic send_resp(input logic [15:0] hdr, input logic [3:0] nb,
                             input logic [63:0] base, output int t0);
        int    eff;
        int    waited;
        logic  got_ack;
        beat_t e;
        eff = (nb == 0) ? 1 : ((nb > 8) ? 8 : int'(nb));
        for (int i = 0; i < eff; i++) begin
            e.hdr  = hdr;
            e.data = (nb == 0) ? 64'h0 : base + 64'(i);
            e.idx  = 3'(i);
            e.last = (i == eff - 1);
            sb.push_back(e);
        end
        for (int i = 0; i < 8; i++) l15_data[i*64 +: 64] = base + 64'(i);
        l15_hdr    = hdr;
        l15_nbeats = nb;
        l15_val    = 1'b1;
        t0         = cyc;
        waited     = 0;
        got_ack    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (l15_ack) begin
                got_ack = 1'b1;
                break;
            end
            waited++;
        end
        checks++;
        if (!got_ack || waited != 1) begin
            errors++;
            $display("FAIL ack_latency: got ack=%0b after %0d cycles required 1 after 1", got_ack, waited + 1);
        end
        @(posedge clk);
        #1;
        l15_val    = 1'b0;
        l15_nbeats = 4'd0;
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_val) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done || out_last !== 1'b0) begin
            errors++;
            $display("FAIL drain: got pending=%0d out_val=%0b out_last=%0b required 0 0 0", sb.size(), out_val, out_last);
        end
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        l15_val    = 1'b0;
        l15_hdr    = 16'h0;
        l15_data   = '0;
        l15_nbeats = 4'd0;
        out_rdy    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_val, out_last, l15_ack} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got val/last/ack=%b required 000", {out_val, out_last, l15_ack});
        end
        checks++;
        if (out_data !== 64'h0 || out_hdr !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: got data=%h hdr=%h required 0 0", out_data, out_hdr);
        end
        checks++;
        if (out_beat_idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_idx: got %0d required 0", out_beat_idx);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Starts in the first cycle out of reset.
    task automatic test_full_line();
        int t0;
        send_resp(16'h1234, 4'd8, 64'h1111_0000, t0);
        for (int i = 0; i < 20 && cyc < t0 + 8; i++) @(negedge clk);
        checks++;
        if (out_val !== 1'b1 || out_last !== 1'b1 || out_beat_idx !== 3'd7) begin
            errors++;
            $display("FAIL full_last_beat: got val=%0b last=%0b idx=%0d required 1 1 7", out_val, out_last, out_beat_idx);
        end
        @(negedge clk);
        checks++;
        if (out_val !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL full_idle_after: got val=%0b last=%0b required 0 0", out_val, out_last);
        end
        wait_drain();
    endtask

    task automatic test_stall();
        int t0;
        @(posedge clk);
        #1;
        fork
            send_resp(16'h5A5A, 4'd8, 64'h1111_0000, t0);
            begin
                repeat (3) @(posedge clk);
                #1;
                out_rdy = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    checks++;
                    if (out_val !== 1'b1 || out_data !== 64'h1111_0002 || out_beat_idx !== 3'd2) begin
                        errors++;
                        $display("FAIL stall_beat: got val=%0b data=%h idx=%0d required 1 0000000011110002 2", out_val, out_data, out_beat_idx);
                    end
                end
                @(posedge clk);
                #1;
                out_rdy = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_zero_beats();
        int t0;
        @(posedge clk);
        #1;
        send_resp(16'hA5A5, 4'd0, 64'h2222_0000, t0);
        wait_drain();
    endtask

    task automatic test_clamp();
        int t0;
        @(posedge clk);
        #1;
        send_resp(16'hC1A4, 4'd12, 64'h3333_0000, t0);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int t0;
        int t1;
        @(posedge clk);
        #1;
        ack_count = 0;
        hs_cycles.delete();
        send_resp(16'hB001, 4'd2, 64'h4444_0000, t0);
        send_resp(16'hB002, 4'd3, 64'h5555_0000, t1);
        wait_drain();
        checks++;
        if (ack_count != 2) begin
            errors++;
            $display("FAIL b2b_acks: got %0d required 2", ack_count);
        end
        checks++;
        if (hs_cycles.size() != 5 || (hs_cycles[4] - hs_cycles[0]) != 4) begin
            errors++;
            $display("FAIL b2b_throughput: got %0d beats spanning %0d cycles required 5 spanning 4",
                     hs_cycles.size(), (hs_cycles.size() == 5) ? hs_cycles[4] - hs_cycles[0] : -1);
        end
    endtask

    task automatic test_reset_mid();
        int   t0;
        logic found;
        @(posedge clk);
        #1;
        send_resp(16'hDEAD, 4'd8, 64'h6666_0000, t0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_val && out_beat_idx == 3'd3) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midreset_reach_idx3: got idx=%0d required 3", out_beat_idx);
        end
        #2;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (out_val !== 1'b0 || l15_ack !== 1'b0) begin
            errors++;
            $display("FAIL midreset_flush: got val=%0b ack=%0b required 0 0", out_val, l15_ack);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_resp(16'hBEEF, 4'd4, 64'h7777_0000, t0);
        wait_drain();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        ack_count = 0;
        test_reset();
        test_full_line();
        test_stall();
        test_zero_beats();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/l15_resp_serializer.md
L15_RESP_SERIALIZER -- requirements
Module: l15_resp_serializer

Interface
REQ-001 Parameter L15_L1D_LINE_SIZE, default 64: response line size in bytes.
REQ-002 Parameter BEAT_BITS, default 64: output beat width in bits.
REQ-003 Parameter HDR_W, default 16: width of the opaque response header (returntype, threadid, flags).
REQ-004 Derived MAX_BEATS = L15_L1D_LINE_SIZE*8/BEAT_BITS; NB_W = clog2(MAX_BEATS)+1.
REQ-005 The line width L15_L1D_LINE_SIZE*8 SHALL be an integer multiple of BEAT_BITS, checked at elaboration.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 l15_val  in  1  L1.5 response valid; held until acknowledged.
REQ-009 l15_hdr  in  HDR_W  response header.
REQ-010 l15_data  in  L15_L1D_LINE_SIZE*8  full response line; beat i is bits [i*BEAT_BITS +: BEAT_BITS].
REQ-011 l15_nbeats  in  NB_W  number of valid beats in the response.
REQ-012 l15_ack  out  1  one-cycle capture acknowledge to the L1.5.
REQ-013 out_val  out  1  beat valid.
REQ-014 out_rdy  in  1  consumer ready.
REQ-015 out_hdr  out  HDR_W  captured header, constant for all beats of a response.
REQ-016 out_data  out  BEAT_BITS  current beat.
REQ-017 out_beat_idx  out  NB_W-1  index of the current beat.
REQ-018 out_last  out  1  high on the final beat of a response.

Function
REQ-019 States: IDLE and SEND.
REQ-020 Capture condition: l15_val & ~l15_ack & (state==IDLE | last-beat handshake this cycle).
REQ-021 On capture, at the same edge: register hdr, data and effective beat count; set idx=0; set state=SEND; set l15_ack=1 for exactly the next cycle.
REQ-022 l15_ack is registered; a val still high during the ack cycle SHALL NOT be captured again.
REQ-023 Effective beat count: nbeats==0 gives 1 header-only beat with out_data=0; nbeats>MAX_BEATS is clamped to MAX_BEATS.
REQ-024 In SEND: out_val=1; out_data = captured line beat idx; out_last = (idx == count-1).
REQ-025 Handshake = out_val & out_rdy; on a non-last handshake idx increments by 1.
REQ-026 On a last-beat handshake: go to SEND with idx=0 if the capture condition holds, otherwise go to IDLE.
REQ-027 While out_val=1 and out_rdy=0, all out_* signals SHALL hold stable.
REQ-028 Throughput SHALL be one beat per cycle with out_rdy=1, including zero bubbles between back-to-back responses.
REQ-029 Response latency SHALL be l15_val high at cycle N (in IDLE), first out_val at cycle N+1.
REQ-030 In IDLE: out_val=0 and out_last=0.

Reset
REQ-031 While rst_n=0 at an edge: state=IDLE, idx=0, l15_ack=0, out_val=0, out_last=0, out_hdr=0, out_data=0.
REQ-032 Reset asserted mid-response SHALL discard the response; out_val SHALL be 0 in the cycle after the reset edge.
REQ-033 The first capture after reset SHALL be possible in the first cycle with rst_n=1.

Verification
REQ-034 Defaults (MAX_BEATS=8), nbeats=8, beat i = 64'h1111_0000+i, out_rdy=1 -> l15_ack at N+1; beats idx 0..7 at cycles N+1..N+8; out_last only at idx 7; state IDLE at N+9.
REQ-035 Same response, out_rdy low for 3 cycles at idx 2 -> out_data=64'h1111_0002 and idx=2 stable throughout; total of 8 beats, none duplicated or dropped.
REQ-036 nbeats=0, hdr=16'hA5A5 -> exactly one beat with out_data=0, out_last=1, out_hdr=16'hA5A5.
REQ-037 nbeats=12 -> exactly 8 beats; out_last at idx 7.
REQ-038 Two queued responses (nbeats=2, then nbeats=3), out_rdy=1 -> 5 beats on consecutive cycles; one l15_ack per response; no double capture.
REQ-039 rst_n=0 during idx 3 -> out_val=0 and l15_ack=0 next cycle; a new response afterwards starts at idx 0.
